// File: rtl/key_expander.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule / key_expander
// Purpose  : key_schedule is one combinational AES-128 key expansion round
//            (RotWord, SubWord, rcon xor, word chaining). key_expander
//            iterates it once per clock to fill an 11-entry round-key file
//            that is read back by index.
// Ports    : clk, rst_n (async, active low)
//            key_in[127:0], key_valid, key_ready  - key load handshake
//            busy, done, keys_valid               - expansion status
//            rk_idx[3:0], rk_out[127:0]           - round-key read port
// Revision : 1.0 - initial release
// ============================================================================

module key_schedule (
  input  logic [127:0] in_bus,
  input  logic [31:0]  rcon,
  output logic [127:0] out_bus
);

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (a^254, which maps 0 to 0)
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = in_bus[127:96];
  assign w1  = in_bus[95:64];
  assign w2  = in_bus[63:32];
  assign w3  = in_bus[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    assign sub[8*b +: 8] = sbox(rot[8*b +: 8]);
  end

  assign temp    = sub ^ rcon;
  assign n0      = w0 ^ temp;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign out_bus = {n0, n1, n2, n3};

endmodule

module key_expander #(
  parameter int NR      = 10,
  parameter int OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;
  localparam logic [3:0] LAST_RND  = 4'(NR);

  logic [0:0]   state;
  logic [127:0] cur;
  logic [31:0]  rcon;
  logic [3:0]   rnd;
  logic [127:0] rk [0:NR];
  logic [127:0] ks_out;
  logic [127:0] rd_data;
  logic         accept;
  logic [7:0]   rcon_next;

  key_schedule u_ks (
    .in_bus  (cur),
    .rcon    (rcon),
    .out_bus (ks_out)
  );

  assign key_ready = (state == ST_IDLE);
  assign busy      = (state == ST_EXPAND);
  assign accept    = key_valid && key_ready;
  assign rcon_next = {rcon[30:24], 1'b0} ^ (rcon[31] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      rcon       <= '0;
      rnd        <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rk[0]      <= key_in;
            cur        <= key_in;
            rcon       <= 32'h0100_0000;
            rnd        <= 4'd1;
            keys_valid <= 1'b0;
            state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          rk[rnd] <= ks_out;
          cur     <= ks_out;
          rcon    <= {rcon_next, 24'h0};
          if (rnd == LAST_RND) begin
            // Final round written: back to IDLE, counter parked at 0.
            rnd        <= 4'd0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range indices read as zero rather than aliasing an entry.
  assign rd_data = (rk_idx <= LAST_RND) ? rk[rk_idx] : '0;

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rk_out <= '0;
      else        rk_out <= rd_data;
    end
  end else begin : g_out_comb
    assign rk_out = rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_expander
// Purpose  : Self-checking bench for key_expander (registered read port).
//            Expected round keys come from a word-level AES-128 key
//            expansion model with a table-built S-box.
// Revision : 1.0 - initial release
// ============================================================================

module tb_key_expander;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int checks = 0;
  int errors = 0;

  key_expander #(.NR(10), .OUT_REG(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [0:255];
  logic [7:0]   rcon_t [0:9];
  logic [127:0] exp_rk [0:10];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) acc = acc ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    logic [7:0] r;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
    r = 8'h01;
    for (int i = 0; i < 10; i++) begin
      rcon_t[i] = r;
      r = ref_mul(r, 8'h02);
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents key, lets it be accepted at the next
  // posedge (T), tracks cycles T+1..T+11 and leaves key_valid/key_in set to
  // next_valid/next_key in the done cycle.
  task automatic run_key(input logic [127:0] key, input bit hold,
                         input bit next_valid, input logic [127:0] next_key);
    int waited = 0;
    while (!key_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {127'h0, key_ready}, 128'h1);
    key_in    = key;
    key_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("ready_low", {127'h0, key_ready}, 128'h0);
      check("busy_high", {127'h0, busy}, 128'h1);
      check("rcon_walk", {96'h0, dut.rcon}, {96'h0, rcon_t[c-1], 24'h0});
      if (c == 1) begin
        check("kv_drop", {127'h0, keys_valid}, 128'h0);
        check("done_low", {127'h0, done}, 128'h0);
      end
      if (hold) key_in = {$urandom, $urandom, $urandom, $urandom};
      else      key_valid = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", {127'h0, done}, 128'h1);
    check("kv_set", {127'h0, keys_valid}, 128'h1);
    check("ready_back", {127'h0, key_ready}, 128'h1);
    key_valid = next_valid;
    key_in    = next_key;
  endtask

  task automatic read_check(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    @(negedge clk);
    rk_idx = idx;
    @(negedge clk);
    check(tag, rk_out, exp);
  endtask

  task automatic readback_all();
    for (int i = 0; i < 16; i++)
      read_check("rk_read", 4'(i), (i <= 10) ? exp_rk[i] : 128'h0);
  endtask

  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] ka, kb;

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_idx = '0;
    build_tables();
    repeat (3) @(negedge clk);
    check("rst_ready", {127'h0, key_ready}, 128'h1);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    check("rst_kv", {127'h0, keys_valid}, 128'h0);
    check("rst_rkout", rk_out, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key with key_valid held and key_in scrambled during expansion
    model_expand(fips_key);
    run_key(fips_key, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("done_once", {127'h0, done}, 128'h0);
    check("kv_hold", {127'h0, keys_valid}, 128'h1);
    check("busy_idle", {127'h0, busy}, 128'h0);
    read_check("fips_rk0", 4'd0, fips_key);
    read_check("fips_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_check("fips_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readback_all();

    // Read latency: idx change shows up one edge later
    read_check("lat_pre", 4'd1, exp_rk[1]);
    rk_idx = 4'd10;
    #1 check("lat_old", rk_out, exp_rk[1]);
    @(negedge clk);
    check("lat_new", rk_out, exp_rk[10]);

    // All-zero key
    model_expand(128'h0);
    run_key(128'h0, 1'b0, 1'b0, '0);
    read_check("zero_rk1", 4'd1, 128'h62636363626363636263636362636363);
    read_check("zero_rk10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    readback_all();

    // Back-to-back: second key presented in the done cycle
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    run_key(ka, 1'b0, 1'b1, kb);
    model_expand(kb);
    run_key(kb, 1'b0, 1'b0, '0);
    readback_all();

    // Reset mid-expansion at T+5
    model_expand(fips_key);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_ready", {127'h0, key_ready}, 128'h1);
    check("mid_busy", {127'h0, busy}, 128'h0);
    check("mid_done", {127'h0, done}, 128'h0);
    check("mid_kv", {127'h0, keys_valid}, 128'h0);
    check("mid_rkout", rk_out, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_nodone", {127'h0, done}, 128'h0);
    end
    read_check("mid_rk1", 4'd1, 128'h0);
    run_key(fips_key, 1'b0, 1'b0, '0);
    readback_all();

    // Randomized keys
    for (int n = 0; n < 4; n++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      model_expand(ka);
      run_key(ka, n[0], 1'b0, '0);
      readback_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
